// File: rtl/ppl_stall_ctrl.sv
// ppl_stall_ctrl: central stall/flush scheduler for the 5-stage pipeline.
// Combines the data-memory handshake, ID-stage load-use and HI/LO hazards,
// mult/div occupancy and the ID-stage branch redirect into enable/flush
// controls for the PC and the four pipeline registers. All hazard outputs are
// combinational so the pipeline registers act on them at the same edge.
module ppl_stall_ctrl #(
    parameter int MULDIV_CYCLES = 32,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       idRs,
    input  logic [4:0]       idRt,
    input  logic             idUseRs,
    input  logic             idUseRt,
    input  logic             idMdOp,
    input  logic             exMemRead,
    input  logic [4:0]       exRt,
    input  logic             mdStart,
    input  logic             branchTaken,
    input  logic             memReq,
    input  logic             memReady,
    output logic             pcContinue,
    output logic             dContinue,
    output logic             dFlush,
    output logic             eContinue,
    output logic             eBubble,
    output logic             mContinue,
    output logic             wBubble,
    output logic             mdBusy,
    output logic [CNT_W-1:0] stallCount
);

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    // Counter reload value: busy for exactly MULDIV_CYCLES cycles, counting
    // down to and including zero.
    localparam logic [7:0] MD_LOAD = 8'(MULDIV_CYCLES - 1);

    md_state_e        state_q, state_d;
    logic [7:0]       mdCnt_q, mdCnt_d;
    logic [CNT_W-1:0] stallCount_q, stallCount_d;

    logic memStall;
    logic rsHit;
    logic rtHit;
    logic luHaz;
    logic mdHaz;
    logic idStall;
    logic mdBusyRaw;

    // Hazard terms. A load writing $zero never creates a dependency.
    assign memStall  = memReq & ~memReady;
    assign rsHit     = idUseRs & (idRs == exRt);
    assign rtHit     = idUseRt & (idRt == exRt);
    assign luHaz     = exMemRead & (exRt != 5'd0) & (rsHit | rtHit);
    assign mdBusyRaw = (state_q == MD_BUSY);
    assign mdHaz     = idMdOp & mdBusyRaw;
    assign idStall   = luHaz | mdHaz;

    assign mdBusy     = mdBusyRaw & ~reset;
    assign stallCount = stallCount_q;

    // Pipeline control priority: memory wait freezes everything, an ID hazard
    // holds PC/IF/ID and drains a bubble into EX, otherwise advance and let a
    // taken branch squash the fetched instruction. Reset forces all to zero.
    always_comb begin
        pcContinue = 1'b0;
        dContinue  = 1'b0;
        dFlush     = 1'b0;
        eContinue  = 1'b0;
        eBubble    = 1'b0;
        mContinue  = 1'b0;
        wBubble    = 1'b0;
        if (!reset) begin
            if (memStall) begin
                // Whole front of the pipe frozen; WB gets a NOP so the
                // stalled MEM instruction is not retired twice. The branch
                // redirect waits, and ID/EX keeps its contents.
                wBubble = 1'b1;
            end else if (idStall) begin
                // Hold the ID instruction (and any pending branch, which is
                // re-evaluated once the hazard clears); EX receives a NOP.
                eContinue = 1'b1;
                eBubble   = 1'b1;
                mContinue = 1'b1;
            end else begin
                pcContinue = 1'b1;
                dContinue  = 1'b1;
                eContinue  = 1'b1;
                mContinue  = 1'b1;
                dFlush     = branchTaken;
            end
        end
    end

    // Mult/div occupancy next-state: accept a start only when EX is actually
    // advancing; once busy, count down regardless of memory stalls.
    always_comb begin
        state_d = state_q;
        mdCnt_d = mdCnt_q;
        case (state_q)
            MD_IDLE: begin
                if (mdStart && !memStall) begin
                    state_d = MD_BUSY;
                    mdCnt_d = MD_LOAD;
                end
            end
            MD_BUSY: begin
                // A stray mdStart here is ignored; mdHaz keeps new ops in ID.
                if (mdCnt_q == 8'd0) begin
                    state_d = MD_IDLE;
                end else begin
                    mdCnt_d = mdCnt_q - 8'd1;
                end
            end
            default: begin
                state_d = MD_IDLE;
                mdCnt_d = 8'd0;
            end
        endcase
    end

    // Performance counter next value: count frozen-PC cycles, saturate.
    always_comb begin
        stallCount_d = stallCount_q;
        if (!pcContinue && (stallCount_q != {CNT_W{1'b1}})) begin
            stallCount_d = stallCount_q + CNT_W'(1);
        end
    end

    // State and counter registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= MD_IDLE;
            mdCnt_q      <= 8'd0;
            stallCount_q <= '0;
        end else begin
            state_q      <= state_d;
            mdCnt_q      <= mdCnt_d;
            stallCount_q <= stallCount_d;
        end
    end

endmodule

// File: tb/tb_ppl_stall_ctrl.sv
// Directed testbench for ppl_stall_ctrl (MULDIV_CYCLES=4, CNT_W=3).
// Output vector order: {pc, d, dFlush, e, eBubble, m, wBubble, mdBusy}.
module tb_ppl_stall_ctrl;

    localparam int MDC = 4;
    localparam int CW  = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [4:0]    idRs, idRt, exRt;
    logic          idUseRs, idUseRt, idMdOp, exMemRead, mdStart;
    logic          branchTaken, memReq, memReady;
    logic          pcContinue, dContinue, dFlush, eContinue, eBubble;
    logic          mContinue, wBubble, mdBusy;
    logic [CW-1:0] stallCount;
    logic [7:0]    outs;

    int checks = 0;
    int errors = 0;

    // Expected output patterns
    localparam logic [7:0] RUN     = 8'b1101_0100;
    localparam logic [7:0] RUN_BR  = 8'b1111_0100;
    localparam logic [7:0] RUN_MD  = 8'b1101_0101;
    localparam logic [7:0] IDST    = 8'b0001_1100;
    localparam logic [7:0] IDST_MD = 8'b0001_1101;
    localparam logic [7:0] MEMST   = 8'b0000_0010;

    assign outs = {pcContinue, dContinue, dFlush, eContinue, eBubble,
                   mContinue, wBubble, mdBusy};

    always #5 clk = ~clk;

    ppl_stall_ctrl #(.MULDIV_CYCLES(MDC), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .idRs(idRs), .idRt(idRt), .idUseRs(idUseRs), .idUseRt(idUseRt),
        .idMdOp(idMdOp), .exMemRead(exMemRead), .exRt(exRt),
        .mdStart(mdStart), .branchTaken(branchTaken),
        .memReq(memReq), .memReady(memReady),
        .pcContinue(pcContinue), .dContinue(dContinue), .dFlush(dFlush),
        .eContinue(eContinue), .eBubble(eBubble), .mContinue(mContinue),
        .wBubble(wBubble), .mdBusy(mdBusy), .stallCount(stallCount)
    );

    task automatic clear_inputs();
        idRs = 5'd0; idRt = 5'd0; exRt = 5'd0;
        idUseRs = 1'b0; idUseRt = 1'b0; idMdOp = 1'b0; exMemRead = 1'b0;
        mdStart = 1'b0; branchTaken = 1'b0; memReq = 1'b0; memReady = 1'b0;
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        clear_inputs();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic set_lu();
        exMemRead = 1'b1; exRt = 5'd8; idRs = 5'd8; idUseRs = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        #2;
        checks++;
        if (outs !== 8'h00) begin
            errors++; $display("FAIL reset_outs: got %b want %b", outs, 8'h00);
        end
        checks++;
        if (stallCount !== 3'd0) begin
            errors++; $display("FAIL reset_cnt: got %0d want 0", stallCount);
        end
        next_cycle();
        reset = 1'b0;
        #1;
        checks++;
        if (outs !== RUN) begin
            errors++; $display("FAIL reset_release: got %b want %b", outs, RUN);
        end
    endtask

    task automatic test_load_use();
        apply_reset();
        set_lu();
        #1;
        checks++;
        if (outs !== IDST) begin
            errors++; $display("FAIL lu_rs_stall: got %b want %b", outs, IDST);
        end
        next_cycle();
        clear_inputs();
        #1;
        checks++;
        if (outs !== RUN) begin
            errors++; $display("FAIL lu_after: got %b want %b", outs, RUN);
        end
        checks++;
        if (stallCount !== 3'd1) begin
            errors++; $display("FAIL lu_cnt: got %0d want 1", stallCount);
        end
        // Dependency through rt
        exMemRead = 1'b1; exRt = 5'd9; idRt = 5'd9; idUseRt = 1'b1;
        #1;
        checks++;
        if (outs !== IDST) begin
            errors++; $display("FAIL lu_rt_stall: got %b want %b", outs, IDST);
        end
        // Same register numbers but the source is not read
        idUseRt = 1'b0;
        #1;
        checks++;
        if (outs !== RUN) begin
            errors++; $display("FAIL lu_unused_src: got %b want %b", outs, RUN);
        end
    endtask

    task automatic test_zero_reg();
        apply_reset();
        exMemRead = 1'b1; exRt = 5'd0; idRs = 5'd0; idUseRs = 1'b1;
        idRt = 5'd0; idUseRt = 1'b1;
        #1;
        checks++;
        if (outs !== RUN) begin
            errors++; $display("FAIL zero_exempt: got %b want %b", outs, RUN);
        end
        next_cycle();
        clear_inputs();
        #1;
        checks++;
        if (stallCount !== 3'd0) begin
            errors++; $display("FAIL zero_cnt: got %0d want 0", stallCount);
        end
    endtask

    task automatic test_muldiv();
        apply_reset();
        mdStart = 1'b1;
        #1;
        checks++;
        if (outs !== RUN) begin
            errors++; $display("FAIL md_issue: got %b want %b", outs, RUN);
        end
        for (int c = 1; c <= MDC; c++) begin
            next_cycle();
            mdStart = (c == 2);  // stray start while busy must be ignored
            idMdOp  = 1'b1;
            #1;
            checks++;
            if (outs !== IDST_MD) begin
                errors++;
                $display("FAIL md_busy_c%0d: got %b want %b", c, outs, IDST_MD);
            end
        end
        next_cycle();
        mdStart = 1'b0;
        #1;
        checks++;
        if (outs !== RUN) begin
            errors++; $display("FAIL md_release: got %b want %b", outs, RUN);
        end
        checks++;
        if (stallCount !== 3'd4) begin
            errors++; $display("FAIL md_cnt: got %0d want 4", stallCount);
        end
    endtask

    task automatic test_mem_branch();
        apply_reset();
        for (int c = 1; c <= 3; c++) begin
            clear_inputs();
            memReq = 1'b1; memReady = 1'b0; branchTaken = 1'b1;
            if (c == 2) set_lu();          // memStall dominates idStall
            if (c == 3) mdStart = 1'b1;    // start not accepted during memStall
            #1;
            checks++;
            if (outs !== MEMST) begin
                errors++;
                $display("FAIL mem_wait_c%0d: got %b want %b", c, outs, MEMST);
            end
            next_cycle();
        end
        clear_inputs();
        memReq = 1'b1; memReady = 1'b1; branchTaken = 1'b1;
        #1;
        checks++;
        if (outs !== RUN_BR) begin
            errors++; $display("FAIL mem_ready: got %b want %b", outs, RUN_BR);
        end
        checks++;
        if (stallCount !== 3'd3) begin
            errors++; $display("FAIL mem_cnt: got %0d want 3", stallCount);
        end
    endtask

    task automatic test_branch_lu();
        apply_reset();
        set_lu();
        branchTaken = 1'b1;
        #1;
        checks++;
        if (outs !== IDST) begin
            errors++; $display("FAIL br_lu_hold: got %b want %b", outs, IDST);
        end
        next_cycle();
        clear_inputs();
        branchTaken = 1'b1;
        #1;
        checks++;
        if (outs !== RUN_BR) begin
            errors++; $display("FAIL br_lu_flush: got %b want %b", outs, RUN_BR);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int c = 0; c < 3; c++) begin
            set_lu();
            next_cycle();
        end
        clear_inputs();
        mdStart = 1'b1;
        #1;
        checks++;
        if (outs !== RUN) begin
            errors++; $display("FAIL rm_issue: got %b want %b", outs, RUN);
        end
        for (int c = 1; c <= 2; c++) begin
            next_cycle();
            mdStart = 1'b0;
            idMdOp  = 1'b1;
        end
        next_cycle();
        #1;
        checks++;
        if (stallCount !== 3'd5 || mdBusy !== 1'b1) begin
            errors++;
            $display("FAIL rm_before: got cnt=%0d busy=%b want cnt=5 busy=1",
                     stallCount, mdBusy);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (outs !== 8'h00) begin
            errors++; $display("FAIL rm_outs: got %b want %b", outs, 8'h00);
        end
        checks++;
        if (stallCount !== 3'd0) begin
            errors++; $display("FAIL rm_cnt: got %0d want 0", stallCount);
        end
        next_cycle();
        reset = 1'b0;
        #1;
        checks++;
        if (outs !== RUN) begin
            errors++; $display("FAIL rm_idle: got %b want %b", outs, RUN);
        end
        idMdOp  = 1'b0;
        mdStart = 1'b1;
        next_cycle();
        mdStart = 1'b0;
        #1;
        checks++;
        if (outs !== RUN_MD) begin
            errors++; $display("FAIL rm_restart: got %b want %b", outs, RUN_MD);
        end
    endtask

    task automatic test_saturate();
        apply_reset();
        for (int c = 0; c < 9; c++) begin
            set_lu();
            next_cycle();
        end
        clear_inputs();
        #1;
        checks++;
        if (stallCount !== 3'd7) begin
            errors++; $display("FAIL sat_cnt: got %0d want 7", stallCount);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_zero_reg();
        test_muldiv();
        test_mem_branch();
        test_branch_lu();
        test_reset_mid();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
